regfile_port_arbiter: RTL and testbench

Two-requester arbiter and initialisation sequencer for the 8-entry register file. Each cycle it grants at most one read and one write, and it drives the register file's separate read and write ports. Reads and writes are arbitrated independently with round-robin fairness. Read data is returned to the winning requester one cycle later. An init sequence zeroes all eight entries without asserting the register file's reset.

---
 rtl/regfile_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter for two requesters onto the register file's read and write ports,
// plus a sequencer that zeroes all eight entries on request.
module regfile_port_arbiter #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r0_req,
    input  logic         r0_we,
    input  logic [2:0]   r0_addr,
    input  logic [N-1:0] r0_wdata,
    input  logic         r1_req,
    input  logic         r1_we,
    input  logic [2:0]   r1_addr,
    input  logic [N-1:0] r1_wdata,
    output logic         r0_gnt,
    output logic         r1_gnt,
    output logic         r0_rvalid,
    output logic         r1_rvalid,
    output logic [N-1:0] r0_rdata,
    output logic [N-1:0] r1_rdata,
    input  logic         init_start,
    output logic         init_busy,
    output logic         rf_read_enable,
    output logic         rf_write_enable,
    output logic [2:0]   rf_read_addr,
    output logic [2:0]   rf_write_addr,
    output logic [N-1:0] rf_write_data,
    input  logic [N-1:0] rf_read_data
);

    localparam int unsigned AW = 3;
    localparam logic [AW-1:0] CNT_LAST = AW'(7);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;
    logic          rd_ptr;
    logic          rd_ptr_nxt;
    logic          wr_ptr;
    logic          wr_ptr_nxt;
    logic [1:0]    rd_cand;
    logic [1:0]    wr_cand;
    logic [1:0]    rd_gnt;
    logic [1:0]    wr_gnt;
    logic          rf_re_c;
    logic          rf_we_c;
    logic [AW-1:0] rf_raddr_c;
    logic [AW-1:0] rf_waddr_c;
    logic [N-1:0]  rf_wdata_c;

    assign rd_cand = {r1_req & ~r1_we, r0_req & ~r0_we};
    assign wr_cand = {r1_req & r1_we, r0_req & r0_we};

    // Pointer value 0 favours requester 0 on a tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            cnt       <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            r0_rvalid <= rd_gnt[0];
            r1_rvalid <= rd_gnt[1];
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        rd_gnt     = 2'b00;
        wr_gnt     = 2'b00;
        rf_re_c    = 1'b0;
        rf_we_c    = 1'b0;
        rf_raddr_c = '0;
        rf_waddr_c = '0;
        rf_wdata_c = '0;
        case (state)
            ST_RUN: begin
                if (rd_cand[0] && (!rd_cand[1] || !rd_ptr)) begin
                    rd_gnt = 2'b01;
                end else if (rd_cand[1]) begin
                    rd_gnt = 2'b10;
                end
                if (wr_cand[0] && (!wr_cand[1] || !wr_ptr)) begin
                    wr_gnt = 2'b01;
                end else if (wr_cand[1]) begin
                    wr_gnt = 2'b10;
                end
                if (rd_gnt[0]) begin
                    rf_re_c    = 1'b1;
                    rf_raddr_c = r0_addr;
                    rd_ptr_nxt = 1'b1;
                end else if (rd_gnt[1]) begin
                    rf_re_c    = 1'b1;
                    rf_raddr_c = r1_addr;
                    rd_ptr_nxt = 1'b0;
                end
                if (wr_gnt[0]) begin
                    rf_we_c    = 1'b1;
                    rf_waddr_c = r0_addr;
                    rf_wdata_c = r0_wdata;
                    wr_ptr_nxt = 1'b1;
                end else if (wr_gnt[1]) begin
                    rf_we_c    = 1'b1;
                    rf_waddr_c = r1_addr;
                    rf_wdata_c = r1_wdata;
                    wr_ptr_nxt = 1'b0;
                end
                if (init_start) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end
            end
            ST_INIT: begin
                rf_we_c    = 1'b1;
                rf_waddr_c = cnt;
                cnt_nxt    = cnt + AW'(1);
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Grants and port enables are held off for as long as reset is asserted.
    assign r0_gnt          = rst & (rd_gnt[0] | wr_gnt[0]);
    assign r1_gnt          = rst & (rd_gnt[1] | wr_gnt[1]);
    assign rf_read_enable  = rst & rf_re_c;
    assign rf_write_enable = rst & rf_we_c;
    assign rf_read_addr    = rf_raddr_c;
    assign rf_write_addr   = rf_waddr_c;
    assign rf_write_data   = rf_wdata_c;
    assign r0_rdata        = rf_read_data;
    assign r1_rdata        = rf_read_data;
    assign init_busy       = (state == ST_INIT);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: a behavioural register file plus a reference model of
// arbitration, read data and the zeroing sequence, driven by directed and random traffic.
module tb_regfile_port_arbiter;

    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req [2];
    logic         we [2];
    logic [2:0]   addr [2];
    logic [N-1:0] wdata [2];
    logic         r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [N-1:0] r0_rdata, r1_rdata;
    logic         init_start, init_busy;
    logic         rf_read_enable, rf_write_enable;
    logic [2:0]   rf_read_addr, rf_write_addr;
    logic [N-1:0] rf_write_data, rf_read_data;

    always #5 clk = ~clk;

    regfile_port_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
        .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
        .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .init_start(init_start), .init_busy(init_busy),
        .rf_read_enable(rf_read_enable), .rf_write_enable(rf_write_enable),
        .rf_read_addr(rf_read_addr), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .rf_read_data(rf_read_data)
    );

    // Register file: synchronous write, one-cycle registered read returning the old value.
    logic [N-1:0] mem [8];
    always @(posedge clk) begin
        if (rf_write_enable) mem[rf_write_addr] <= rf_write_data;
        if (rf_read_enable)  rf_read_data <= mem[rf_read_addr];
    end

    // Reference model state
    int           n_cmp = 0;
    int           n_err = 0;
    int           fav_rd, fav_wr;
    bit           in_init;
    int           init_addr;
    logic [N-1:0] ref_mem [8];
    bit           exp_rv [2];
    bit           exp_g [2];
    logic [N-1:0] exp_rd;

    logic         obs_g0, obs_g1, obs_rv0, obs_rv1, obs_busy;
    logic [N-1:0] obs_rd0, obs_rd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check the DUT against the model, then advance the model at the edge.
    task automatic cycle();
        int rw, ww;
        bit rc [2];
        bit wc [2];
        #2;
        obs_g0 = r0_gnt;  obs_g1 = r1_gnt;
        obs_rv0 = r0_rvalid; obs_rv1 = r1_rvalid;
        obs_rd0 = r0_rdata;  obs_rd1 = r1_rdata;
        obs_busy = init_busy;
        chk("r0_rvalid", 32'(r0_rvalid), 32'(exp_rv[0]));
        chk("r1_rvalid", 32'(r1_rvalid), 32'(exp_rv[1]));
        if (exp_rv[0]) chk("r0_rdata", 32'(r0_rdata), 32'(exp_rd));
        if (exp_rv[1]) chk("r1_rdata", 32'(r1_rdata), 32'(exp_rd));
        chk("init_busy", 32'(init_busy), 32'(in_init));
        rw = -1;
        ww = -1;
        if (!in_init) begin
            for (int i = 0; i < 2; i++) begin
                rc[i] = req[i] && !we[i];
                wc[i] = req[i] && we[i];
            end
            if (rc[0] && rc[1]) rw = fav_rd;
            else if (rc[0])     rw = 0;
            else if (rc[1])     rw = 1;
            if (wc[0] && wc[1]) ww = fav_wr;
            else if (wc[0])     ww = 0;
            else if (wc[1])     ww = 1;
        end
        exp_g[0] = (rw == 0) || (ww == 0);
        exp_g[1] = (rw == 1) || (ww == 1);
        chk("r0_gnt", 32'(r0_gnt), 32'(exp_g[0]));
        chk("r1_gnt", 32'(r1_gnt), 32'(exp_g[1]));
        chk("rf_re", 32'(rf_read_enable), 32'(rw >= 0));
        if (rw >= 0) chk("rf_raddr", 32'(rf_read_addr), 32'(addr[rw]));
        chk("rf_we", 32'(rf_write_enable), 32'(in_init || ww >= 0));
        if (in_init) begin
            chk("init_waddr", 32'(rf_write_addr), 32'(init_addr));
            chk("init_wdata", 32'(rf_write_data), 32'(0));
        end else if (ww >= 0) begin
            chk("rf_waddr", 32'(rf_write_addr), 32'(addr[ww]));
            chk("rf_wdata", 32'(rf_write_data), 32'(wdata[ww]));
        end
        @(posedge clk);
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        if (in_init) begin
            ref_mem[init_addr] = '0;
            init_addr++;
            if (init_addr == 8) in_init = 1'b0;
        end else begin
            if (rw >= 0) begin
                exp_rv[rw] = 1'b1;
                exp_rd     = ref_mem[addr[rw]];
                fav_rd     = 1 - rw;
            end
            if (ww >= 0) begin
                ref_mem[addr[ww]] = wdata[ww];
                fav_wr            = 1 - ww;
            end
            if (init_start) begin
                in_init   = 1'b1;
                init_addr = 0;
            end
        end
        @(negedge clk);
    endtask

    // Asserts reset for one edge; outputs must fall to reset values at once.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_r0_gnt", 32'(r0_gnt), 32'(0));
        chk("rst_r1_gnt", 32'(r1_gnt), 32'(0));
        chk("rst_rf_re", 32'(rf_read_enable), 32'(0));
        chk("rst_rf_we", 32'(rf_write_enable), 32'(0));
        chk("rst_busy", 32'(init_busy), 32'(0));
        chk("rst_r0_rvalid", 32'(r0_rvalid), 32'(0));
        chk("rst_r1_rvalid", 32'(r1_rvalid), 32'(0));
        in_init = 1'b0;
        fav_rd = 0;
        fav_wr = 0;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        exp_g[0] = 1'b0;  exp_g[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_req(input int i, input bit r, input bit w, input logic [2:0] a,
                           input logic [N-1:0] d);
        req[i] = r; we[i] = w; addr[i] = a; wdata[i] = d;
    endtask

    task automatic idle();
        req[0] = 1'b0;
        req[1] = 1'b0;
        init_start = 1'b0;
    endtask

    task automatic preload(input logic [N-1:0] base);
        idle();
        for (int a = 0; a < 8; a++) begin
            set_req(0, 1'b1, 1'b1, 3'(a), base + N'(a));
            cycle();
        end
        idle();
    endtask

    task automatic read_back(input int who, input logic [2:0] a, output logic [N-1:0] d);
        idle();
        set_req(who, 1'b1, 1'b0, a, '0);
        cycle();
        idle();
        cycle();
        d = (who == 0) ? obs_rd0 : obs_rd1;
    endtask

    logic [N-1:0] d;
    int           busy_cnt;

    initial begin
        for (int a = 0; a < 8; a++) ref_mem[a] = '0;
        exp_rd = '0;
        rst = 1'b0;
        init_start = 1'b0;
        set_req(0, 1'b1, 1'b0, 3'd1, '0);
        set_req(1, 1'b1, 1'b1, 3'd2, 16'h5555);
        @(negedge clk);
        do_reset();
        preload(16'hA000);

        // Write then read back address 5
        set_req(0, 1'b1, 1'b1, 3'd5, 16'h1234);
        cycle();
        chk("t1_wr_gnt", 32'(obs_g0), 32'(1));
        read_back(0, 3'd5, d);
        chk("t1_rvalid", 32'(obs_rv0), 32'(1));
        chk("t1_rdata", 32'(d), 32'h1234);

        // r1 reads alone so the read pointer favours r0, then both contend
        read_back(1, 3'd0, d);
        set_req(0, 1'b1, 1'b0, 3'd1, '0);
        set_req(1, 1'b1, 1'b0, 3'd2, '0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t2_r0_gnt", 32'(obs_g0), 32'(k % 2 == 0));
            chk("t2_r1_gnt", 32'(obs_g1), 32'(k % 2 == 1));
            if (k > 0) chk("t2_r0_rv", 32'(obs_rv0), 32'(k % 2 == 1));
        end
        idle();
        cycle();
        chk("t2_r1_rv_last", 32'(obs_rv1), 32'(1));
        chk("t2_rdata_last", 32'(obs_rd1), 32'hA002);

        // Read and write of address 3 in the same cycle
        set_req(0, 1'b1, 1'b0, 3'd3, '0);
        set_req(1, 1'b1, 1'b1, 3'd3, 16'hBEEF);
        cycle();
        chk("t3_r0_gnt", 32'(obs_g0), 32'(1));
        chk("t3_r1_gnt", 32'(obs_g1), 32'(1));
        idle();
        cycle();
        chk("t3_old", 32'(obs_rd0), 32'hA003);
        read_back(0, 3'd3, d);
        chk("t3_new", 32'(d), 32'hBEEF);

        // Write contention on address 0
        set_req(0, 1'b1, 1'b1, 3'd0, 16'h1111);
        set_req(1, 1'b1, 1'b1, 3'd0, 16'h2222);
        cycle();
        chk("t4_first_r0", 32'(obs_g0), 32'(1));
        cycle();
        chk("t4_second_r1", 32'(obs_g1), 32'(1));
        read_back(0, 3'd0, d);
        chk("t4_final", 32'(d), 32'h2222);

        // Init sequence with r1 requesting reads around it
        preload(16'hB000);
        init_start = 1'b1;
        set_req(1, 1'b1, 1'b0, 3'd6, '0);
        cycle();
        chk("t5_s_gnt", 32'(obs_g1), 32'(1));
        init_start = 1'b0;
        set_req(1, 1'b1, 1'b0, 3'd7, '0);
        busy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            busy_cnt += int'(obs_busy);
            chk("t5_no_gnt", 32'(obs_g1), 32'(0));
        end
        cycle();
        chk("t5_run_busy", 32'(obs_busy), 32'(0));
        chk("t5_run_gnt", 32'(obs_g1), 32'(1));
        chk("t5_busy_cycles", 32'(busy_cnt), 32'(8));
        idle();
        for (int a = 0; a < 8; a++) begin
            read_back(0, 3'(a), d);
            chk("t5_zero", 32'(d), 32'(0));
        end

        // Reset during the cnt=3 init cycle
        preload(16'hC000);
        init_start = 1'b1;
        cycle();
        init_start = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        set_req(0, 1'b1, 1'b0, 3'd4, '0);
        do_reset();
        cycle();
        idle();
        for (int a = 0; a < 8; a++) begin
            read_back(0, 3'(a), d);
            chk("t6_mem", 32'(d), (a < 3) ? 32'(0) : 32'(16'hC000 + 16'(a)));
        end

        // Random traffic; each request is held until the model says it was granted
        idle();
        exp_g[0] = 1'b0; exp_g[1] = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] || exp_g[i]) begin
                    set_req(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                            3'($urandom_range(0, 7)), N'($urandom));
                end
            end
            init_start = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 149) == 0) do_reset();
            else cycle();
        end
        idle();
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
